// File: rtl/ims1420_ctrl.sv
// Byte-wide valid/ready front end for one IMS1420 4K x 4 SRAM.
// Each byte access becomes a low-nibble then high-nibble access; the SRAM can be zero-filled after reset.
module ims1420_ctrl #(
    parameter int ADDR_W         = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-2:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [3:0]        sram_wdata,
    input  logic [3:0]        sram_rdata,
    output logic              sram_we_b,
    output logic              sram_e_b
);

    // state | meaning
    // CLEAR | zero-fill, one nibble write per cycle
    // IDLE  | SRAM idle, request port open
    // LO    | low nibble access at {A,0}
    // HI    | high nibble access at {A,1}
    typedef enum logic [1:0] {CLEAR, IDLE, LO, HI} state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;
    localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic [ADDR_W-1:0] cnt, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [3:0]        rdata_lo, rdata_lo_d;

    logic              rsp_valid_d;
    logic [7:0]        rsp_rdata_d;
    logic              init_done_d;
    logic [ADDR_W-1:0] sram_addr_d;
    logic [3:0]        sram_wdata_d;
    logic              sram_we_b_d;
    logic              sram_e_b_d;

    logic accept;
    logic clr_last;

    // init_done gates ready so the port stays closed through reset even when no clear runs
    assign req_ready = (state == IDLE) && init_done;
    assign accept    = req_valid && req_ready;
    // the write to the top nibble address is in flight during this cycle
    assign clr_last  = !sram_e_b && (&sram_addr);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR: if (clr_last) state_nxt = IDLE;
            IDLE:  if (accept) state_nxt = LO;
            LO:    state_nxt = HI;
            HI:    state_nxt = IDLE;
            default: state_nxt = RESET_STATE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_lo_d   = rdata_lo;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata;
        init_done_d  = init_done;
        sram_addr_d  = sram_addr;
        sram_wdata_d = sram_wdata;
        sram_we_b_d  = 1'b1;
        sram_e_b_d   = 1'b1;
        unique case (state)
            CLEAR: begin
                if (clr_last) begin
                    init_done_d = 1'b1;
                end else begin
                    sram_addr_d  = cnt;
                    sram_wdata_d = 4'h0;
                    sram_we_b_d  = 1'b0;
                    sram_e_b_d   = 1'b0;
                    cnt_d        = cnt + CNT_ONE;
                end
            end
            IDLE: begin
                init_done_d = 1'b1;
                if (accept) begin
                    we_d         = req_we;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    sram_addr_d  = {req_addr, 1'b0};
                    sram_wdata_d = req_wdata[3:0];
                    sram_we_b_d  = ~req_we;
                    sram_e_b_d   = 1'b0;
                end
            end
            LO: begin
                rdata_lo_d   = sram_rdata;
                sram_addr_d  = {addr_q, 1'b1};
                sram_wdata_d = wdata_q[7:4];
                sram_we_b_d  = ~we_q;
                sram_e_b_d   = 1'b0;
            end
            HI: begin
                if (!we_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = {sram_rdata, rdata_lo};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            rdata_lo   <= 4'h0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 8'h00;
            init_done  <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= 4'h0;
            sram_we_b  <= 1'b1;
            sram_e_b   <= 1'b1;
        end else begin
            cnt        <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_lo   <= rdata_lo_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rsp_rdata_d;
            init_done  <= init_done_d;
            sram_addr  <= sram_addr_d;
            sram_wdata <= sram_wdata_d;
            sram_we_b  <= sram_we_b_d;
            sram_e_b   <= sram_e_b_d;
        end
    end

endmodule
